// File: rtl/rv32_isa_pkg.sv
// Shared RV32I encoding constants: major opcodes, instruction formats,
// encoder error codes and immediate range limits.
package rv32_isa_pkg;

  // Major opcodes, i.e. opcode[6:2]; opcode[1:0] is always 2'b11 for RV32I.
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_J = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_FMT   = 2'd3
  } err_e;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational RV32I field packer: places registers, functs and the
// immediate per format and flags illegal format / misaligned / out-of-range.
module imm_pack
  import rv32_isa_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic [1:0]  err_code_o
);

  logic signed [31:0] imm_s;
  logic signed [31:0] lo;
  logic signed [31:0] hi;
  logic               legal;
  logic               need_align;

  assign imm_s = $signed(imm_i);

  always_comb begin
    instr_o    = '0;
    lo         = '0;
    hi         = '0;
    legal      = 1'b1;
    need_align = 1'b0;
    case (fmt_i)
      FMT_R: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        lo      = IMM12_MIN;
        hi      = IMM12_MAX;
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        lo      = IMM12_MIN;
        hi      = IMM12_MAX;
      end
      FMT_B: begin
        instr_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
        lo         = IMM_B_MIN;
        hi         = IMM_B_MAX;
        need_align = 1'b1;
      end
      FMT_J: begin
        instr_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                      rd_i, opcode_i};
        lo         = IMM_J_MIN;
        hi         = IMM_J_MAX;
        need_align = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // R-format has lo == hi == 0 and skips the range check entirely.
  always_comb begin
    err_code_o = ERR_NONE;
    if (!legal) begin
      err_code_o = ERR_FMT;
    end else if (need_align && imm_i[0]) begin
      err_code_o = ERR_ALIGN;
    end else if (fmt_i != FMT_R && (imm_s < lo || imm_s > hi)) begin
      err_code_o = ERR_RANGE;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and
// streams them to instruction memory at sequential word addresses.
module instr_encoder
  import rv32_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [31:0]       pack_instr;
  logic [1:0]        pack_err;
  logic              accept;
  logic              wr_hs;

  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [31:0]       wr_data_q,  wr_data_d;
  logic              err_q,      err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  imm_pack u_imm_pack (
    .fmt_i      (fmt_i),
    .opcode_i   (opcode_i),
    .rd_i       (rd_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .funct3_i   (funct3_i),
    .funct7_i   (funct7_i),
    .imm_i      (imm_i),
    .instr_o    (pack_instr),
    .err_code_o (pack_err)
  );

  assign req_ready_o = !start_i && (!wr_valid_q || wr_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign wr_hs       = wr_valid_q && wr_ready_i;

  // wr_addr_q is the address of the word currently held (or next to be held);
  // it advances only on a completed handshake.
  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    if (start_i) begin
      wr_valid_d = 1'b0;
      wr_addr_d  = start_addr_i & ~ADDR_W'(3);
      count_d    = '0;
    end else begin
      if (wr_hs) begin
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q + ADDR_W'(4);
        count_d    = (count_q == '1) ? count_q : count_q + CNT_W'(1);
      end
      if (accept) begin
        if (pack_err != ERR_NONE) begin
          err_d      = 1'b1;
          err_code_d = pack_err;
        end else begin
          wr_valid_d = 1'b1;
          wr_data_d  = pack_instr;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      count_q    <= '0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      count_q    <= count_d;
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign count_o    = count_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded RV32I fields (format, opcode, registers, functs, signed immediate) into 32-bit instruction words.
- Streams the encoded words into instruction memory at sequential word addresses.
- Inverse of the immediate generator: used by the self-test loader and the program-download path that fills IM before the Single_CPU core leaves reset.
- Registered, one-deep output with valid/ready backpressure on both sides.

Parameters:
ADDR_W, 32, width of the instruction-memory byte address
CNT_W, 16, width of the written-instruction counter (saturating)

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  load address counter from start_addr_i; flushes pending output
start_addr_i  in  ADDR_W  new base byte address (bits [1:0] forced to 0)
req_valid_i  in  1  encode request valid
req_ready_o  out  1  encoder can accept a request this cycle
fmt_i  in  3  0=R 1=I 2=S 3=B 4=J; 5..7 illegal
opcode_i  in  7  opcode field, copied verbatim to [6:0]
rd_i  in  5  destination register
rs1_i  in  5  source register 1
rs2_i  in  5  source register 2
funct3_i  in  3  funct3 field
funct7_i  in  7  funct7 field (R only)
imm_i  in  32  signed immediate, byte offset for B/J
wr_valid_o  out  1  IM write request valid
wr_ready_i  in  1  IM accepts the write
wr_addr_o  out  ADDR_W  byte address of the write
wr_data_o  out  32  encoded instruction
err_o  out  1  one-cycle pulse: request rejected
err_code_o  out  2  0 none, 1 imm out of range, 2 imm misaligned, 3 illegal fmt
count_o  out  CNT_W  instructions successfully written

Behaviour:
- Reset (async, rst_n_i=0): wr_valid_o=0, wr_addr_o=0, wr_data_o=0, err_o=0, err_code_o=0, count_o=0. Reset mid-transfer drops any pending word.
- Ready: req_ready_o = !start_i && (!wr_valid_o || wr_ready_i).
- Accept: req_valid_i && req_ready_o.
- Encoding, bit placement per RV32I:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - R ignores imm_i. Fields unused by a format are ignored.
- Range checks, applied to the full 32-bit signed imm_i:
  - I/S: -2048..2047.
  - B: -4096..4094.
  - J: -1048576..1048574.
  - B/J: imm_i[0] must be 0.
  - Priority: illegal fmt (3) > misaligned (2) > range (1).
- Accepted valid request: wr_data_o/wr_valid_o are registered the next cycle (latency 1), with wr_addr_o = current address.
- Accepted erroneous request: the request is consumed, err_o and err_code_o pulse for one cycle, no write is issued, and wr_valid_o keeps its prior state.
- err_code_o returns to 0 when err_o is low.
- Write handshake (wr_valid_o && wr_ready_i):
  - Address += 4, wrapping modulo 2^ADDR_W.
  - count_o += 1, saturating at all-ones.
  - If a new valid request is accepted in the same cycle, wr_valid_o stays 1 with the new data at the incremented address (back-to-back, one word per cycle).
- Stall: while wr_valid_o && !wr_ready_i, wr_addr_o and wr_data_o are held stable and req_ready_o=0.
- start_i (highest priority):
  - Next cycle: wr_valid_o=0, address = {start_addr_i[ADDR_W-1:2],2'b00}, count_o=0.
  - Requests are not accepted in the start_i cycle.
  - A pending word is dropped even if wr_ready_i=1 in that cycle; it is not counted.

Decomposition:
- Shared package rv32_isa_pkg:
  - 5-bit opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR), also used by the immediate generator.
  - fmt encodings (FMT_R..FMT_J).
  - err codes.
  - Immediate range limits.
- Sub-module imm_pack: purely combinational. Takes fmt + fields + imm and returns instr[31:0] plus err_code. The top level holds the address counter, output register, handshake and counter.

Test Plan:
- Reset, then start_addr_i=0x100, then I-type op=0x13 rd=1 rs1=2 f3=0 imm=-1, wr_ready_i=1 -> next cycle wr_data_o=0xFFF10093, wr_addr_o=0x100, count_o=1 after the handshake.
- Back-to-back S (op=0x23 rs1=2 rs2=5 f3=2 imm=8) then B (op=0x63 rs1=rs2=0 f3=0 imm=-4) -> 0x00512423 at 0x100, then 0xFE000EE3 at 0x104, on consecutive cycles.
- J op=0x6F rd=1 imm=2048 with wr_ready_i held low 3 cycles -> wr_data_o=0x001000EF held stable, req_ready_o=0 during the stall, address unchanged, one write when ready rises.
- I imm=2048 -> err_o=1, code 1; B imm=3 -> code 2; fmt=6 -> code 3; no wr_valid_o, count_o unchanged.
- Address 0xFFFFFFFC plus two writes -> second write at 0x00000000.
- start_i while a word is stalled, and rst_n_i asserted mid-stall -> word dropped, count_o=0, wr_valid_o=0 immediately on reset.
